// File: rtl/rv32_alu_decode_stage.sv
// rv32_alu_decode_stage: RV32I decode stage producing a registered, fully
// decoded integer ALU command for the exec stage over valid/ready.
//
// Optional build macro: RV32_DECODE_SKID_EN
//   undefined : single output register, in_ready = !out_valid | out_ready
//   defined   : adds a 1-entry skid register so in_ready is purely registered
//               (in_ready = !skid_valid), cutting the out_ready -> in_ready path.

package rv32_alu_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SLL  = 4'd1,
    ALU_OP_SLT  = 4'd2,
    ALU_OP_SLTU = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SRL  = 4'd5,
    ALU_OP_OR   = 4'd6,
    ALU_OP_AND  = 4'd7,
    ALU_OP_SRA  = 4'd8,
    ALU_OP_SUB  = 4'd9
  } int_alu_op_t;

  localparam logic [1:0] OP1_RS1    = 2'd0;
  localparam logic [1:0] OP1_PC     = 2'd1;
  localparam logic [1:0] OP1_ZERO   = 2'd2;

  localparam logic [1:0] OP2_RS2    = 2'd0;
  localparam logic [1:0] OP2_IMM    = 2'd1;
  localparam logic [1:0] OP2_CONST4 = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // One decoded command; also the unit of storage in the output/skid regs.
  typedef struct packed {
    int_alu_op_t opsel;
    logic [1:0]  op1_sel;
    logic [1:0]  op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        illegal;
    logic [31:0] pc;
  } alu_cmd_t;

endpackage

module rv32_alu_decode_stage
  import rv32_alu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output int_alu_op_t out_opsel,
  output logic [1:0]  out_op1_sel,
  output logic [1:0]  out_op2_sel,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_is_branch,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  // Base funct3 -> ALU op map shared by OP and OP-IMM (funct7 qualifies later).
  function automatic int_alu_op_t f3_to_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_OP_ADD;
      3'b001:  return ALU_OP_SLL;
      3'b010:  return ALU_OP_SLT;
      3'b011:  return ALU_OP_SLTU;
      3'b100:  return ALU_OP_XOR;
      3'b101:  return ALU_OP_SRL;
      3'b110:  return ALU_OP_OR;
      default: return ALU_OP_AND;
    endcase
  endfunction

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  alu_cmd_t dec;

  // Combinational decode of the presented instruction.
  always_comb begin
    dec           = '0;
    dec.opsel     = ALU_OP_ADD;
    dec.op1_sel   = OP1_RS1;
    dec.op2_sel   = OP2_RS2;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.pc        = in_pc;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (f7 == 7'b0000000)
          dec.opsel = f3_to_op(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000)
          dec.opsel = ALU_OP_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)
          dec.opsel = ALU_OP_SRA;
        else
          dec.illegal = 1'b1;
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.op2_sel   = OP2_IMM;
        dec.imm       = imm_i;
        dec.opsel     = f3_to_op(f3);
        // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
        if (f3 == 3'b001 && f7 != 7'b0000000)
          dec.illegal = 1'b1;
        else if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)
            dec.opsel = ALU_OP_SRA;
          else if (f7 != 7'b0000000)
            dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.op1_sel   = OP1_ZERO;
        dec.op2_sel   = OP2_IMM;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.op1_sel   = OP1_PC;
        dec.op2_sel   = OP2_IMM;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        // ALU computes the link address; target uses imm separately.
        dec.reg_write = 1'b1;
        dec.op1_sel   = OP1_PC;
        dec.op2_sel   = OP2_CONST4;
        dec.imm       = imm_j;
      end
      OPC_JALR: begin
        dec.reg_write = 1'b1;
        dec.op1_sel   = OP1_PC;
        dec.op2_sel   = OP2_CONST4;
        dec.imm       = imm_i;
        if (f3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.imm       = imm_b;
        case (f3)
          3'b000, 3'b001: dec.opsel = ALU_OP_SUB;
          3'b100, 3'b101: dec.opsel = ALU_OP_SLT;
          3'b110, 3'b111: dec.opsel = ALU_OP_SLTU;
          default:        dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.reg_write = 1'b1;
        dec.op2_sel   = OP2_IMM;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.op2_sel   = OP2_IMM;
        dec.imm       = imm_s;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal commands still flow downstream but must not have side effects.
    if (dec.illegal) begin
      dec.opsel     = ALU_OP_ADD;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  alu_cmd_t cmd_rst;

  // Reset image of a command register: all zero, opsel ADD, pc RESET_PC.
  always_comb begin
    cmd_rst       = '0;
    cmd_rst.opsel = ALU_OP_ADD;
    cmd_rst.pc    = RESET_PC;
  end

  logic     out_valid_q, out_valid_d;
  alu_cmd_t out_cmd_q, out_cmd_d;
  logic     out_free;

  assign out_free = !out_valid_q || out_ready;

`ifdef RV32_DECODE_SKID_EN
  logic     skid_valid_q, skid_valid_d;
  alu_cmd_t skid_cmd_q, skid_cmd_d;

  assign in_ready = !skid_valid_q;

  // Output/skid next state: skid drains first so order is preserved.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_cmd_d    = out_cmd_q;
    skid_valid_d = skid_valid_q;
    skid_cmd_d   = skid_cmd_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_cmd_d    = skid_cmd_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_valid;
        if (in_valid) out_cmd_d = dec;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_cmd_d   = dec;
    end
  end

  // Skid register.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_cmd_q   <= cmd_rst;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_cmd_q   <= skid_cmd_d;
    end
  end
`else
  assign in_ready = out_free;

  // Output next state: load on accept, hold on stall, kill on flush.
  always_comb begin
    out_valid_d = out_valid_q;
    out_cmd_d   = out_cmd_q;
    if (flush)
      out_valid_d = 1'b0;
    else if (in_ready) begin
      out_valid_d = in_valid;
      if (in_valid) out_cmd_d = dec;
    end
  end
`endif

  // Output command register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_cmd_q   <= cmd_rst;
    end else begin
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opsel     = out_cmd_q.opsel;
  assign out_op1_sel   = out_cmd_q.op1_sel;
  assign out_op2_sel   = out_cmd_q.op2_sel;
  assign out_imm       = out_cmd_q.imm;
  assign out_rs1       = out_cmd_q.rs1;
  assign out_rs2       = out_cmd_q.rs2;
  assign out_rd        = out_cmd_q.rd;
  assign out_reg_write = out_cmd_q.reg_write;
  assign out_is_branch = out_cmd_q.is_branch;
  assign out_illegal   = out_cmd_q.illegal;
  assign out_pc        = out_cmd_q.pc;

endmodule

// File: doc/rv32_alu_decode_stage.md
Name: rv32_alu_decode_stage

Overview:
Decode-stage producer of the integer ALU command interface. It consumes fetched RV32I instructions over a valid/ready handshake. It emits a registered, fully decoded ALU command to the exec stage: int_alu_op_t opsel, operand selects, immediate, register indices and write-enable. It holds the command under downstream stall and drops it on pipeline flush.

Parameters:
RESET_PC, 32'h0000_0000, value driven on out_pc while out_valid=0 after reset

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising clk
flush  in  1  synchronous kill of the held and the incoming instruction
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  32  raw RV32I instruction word
in_pc  in  32  instruction address
out_valid  out  1  registered command valid
out_ready  in  1  exec stage consumes the command
out_opsel  out  int_alu_op_t  ALU operation: ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND/SRA/SUB
out_op1_sel  out  2  0=RS1, 1=PC, 2=ZERO
out_op2_sel  out  2  0=RS2, 1=IMM, 2=CONST4
out_imm  out  32  sign-extended immediate (I/S/B/U/J by format)
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_reg_write  out  1  result written to rd (forced 0 when rd=0)
out_is_branch  out  1  conditional branch; ALU result is the compare
out_illegal  out  1  undecodable instruction
out_pc  out  32  registered in_pc

Behaviour:
- Reset: out_valid=0, out_pc=RESET_PC, all other outputs 0 (opsel=ALU_OP_ADD). Reset overrides flush and the handshake.
- Transfer: in_valid & in_ready loads the decoded command on the next edge; latency 1 cycle. out_valid & out_ready retires it.
- in_ready = !out_valid | out_ready (no macro). Back-to-back accept at 1 instr/cycle.
- Stall: out_valid=1 & out_ready=0 -> every out_* held stable, in_ready=0.
- Flush: next edge out_valid=0, and any same-cycle input is discarded. With flush asserted, in_ready is still driven per the rule above, but the accepted instruction is dropped.
- OP (0110011): funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000 is valid only with f3=000 (SUB) or f3=101 (SRA). Any other funct7 -> illegal. op1=RS1, op2=RS2.
- OP-IMM (0010011): same map, op2=IMM (I-type). SLLI requires imm[11:5]=0. SRLI/SRAI require imm[11:5]=0000000/0100000. Otherwise illegal.
- LUI: ZERO+IMM(U), ADD. AUIPC: PC+IMM(U), ADD.
- JAL/JALR: PC+CONST4, ADD, imm=J/I-imm. JALR requires f3=000.
- BRANCH: RS1 vs RS2, reg_write=0, is_branch=1. BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLTU. f3=010/011 illegal.
- LOAD/STORE: RS1+IMM, ADD. reg_write=1 for load only. S-imm for store.
- Illegal (any other opcode or bad field): illegal=1, opsel=ADD, reg_write=0, is_branch=0. out_valid is still 1.
- Immediates: bit 31 sign-extends. B/J imm bit 0 is 0. U imm low 12 bits are 0.

Optional Feature:
RV32_DECODE_SKID_EN:
- Defined: a 1-entry skid register breaks the combinational in_ready←out_ready path; in_ready = !skid_valid (registered).
  - An accept while the output is stalled lands in skid. Skid drains to output when out_ready.
  - Order is preserved. Flush clears both entries. Reset clears skid_valid.
- Undefined: no skid storage, in_ready as above.

Test Plan:
- reset held 2 cycles with in_valid=1 -> out_valid=0, out_pc=RESET_PC, opsel=ADD; first command appears 1 cycle after reset release.
- in_instr=32'h40B50533 (sub a0,a0,a1), out_ready=1 -> next cycle opsel=SUB, op1_sel=0, op2_sel=0, rd=10, rs1=10, rs2=11, reg_write=1.
- in_instr=32'hFFF00093 (addi x1,x0,-1) -> opsel=ADD, op2_sel=1, out_imm=32'hFFFFFFFF; 32'h4050D093 (srai x1,x1,5) -> opsel=SRA, imm[4:0]=5.
- Branch 32'hFE209EE3 (bne x1,x2,-4) -> opsel=SUB, is_branch=1, reg_write=0, out_imm=32'hFFFFFFFC. Then 32'h0000000B -> illegal=1, reg_write=0.
- Stall: out_ready=0 for 3 cycles with new in_valid -> in_ready=0 (no macro), outputs unchanged. With RV32_DECODE_SKID_EN, exactly one extra instruction is accepted, then both retire in order.
- Flush while out_valid=1 & out_ready=0 and in_valid=1 -> out_valid=0 next cycle, neither instruction ever appears.
